// File: rtl/data_mem_wb.sv
// Data-memory and write-back stage: byte-laned data RAM, b/h/w loads and stores
// with sign/zero extension, multi-cycle load with stall, and Res source select.
module data_mem_wb #(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [1:0]  wb_sel,
  input  logic [31:0] ALUOut,
  input  logic [31:0] rs2,
  input  logic [31:0] PC,
  input  logic [31:0] PC_4,
  output logic [31:0] Res,
  output logic        stall,
  output logic        err
);

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int CNT_W     = 2;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [1:0]        lane;
    logic [2:0]        f3;
  } ld_req_t;

  state_t                          state, state_nx;
  logic [CNT_W-1:0]                cnt, cnt_nx;
  ld_req_t                         cur_req, req_q, rd_req;
  logic [31:0]                     load_q, load_ext;
  logic                            fill;
  logic                            ld_f3_ok, st_f3_ok, is_half, is_word;
  logic                            oor, misal, illegal, err_raw;
  logic                            load_go, store_go;
  logic [NUM_LANES-1:0]            be;
  logic [NUM_LANES-1:0][VEC_W-1:0] wdata, rd_word;
  logic [7:0]                      sel_b;
  logic [15:0]                     sel_h;

  assign cur_req = {ALUOut[ADDR_W+1:2], ALUOut[1:0], funct3};

  // Request checking
  always_comb begin
    ld_f3_ok = 1'b0;
    st_f3_ok = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: begin
        ld_f3_ok = 1'b1;
        st_f3_ok = 1'b1;
      end
      3'b100, 3'b101: ld_f3_ok = 1'b1;
      default: ;
    endcase
  end

  assign is_half = (funct3[1:0] == 2'b01);
  assign is_word = (funct3[1:0] == 2'b10);
  assign oor     = |ALUOut[31:ADDR_W+2];
  assign misal   = (is_half & ALUOut[0]) | (is_word & (|ALUOut[1:0]));
  assign illegal = (MemRead & MemWrite) | (MemRead & ~ld_f3_ok) | (MemWrite & ~st_f3_ok);
  assign err_raw = (MemRead | MemWrite) & (illegal | misal | oor);
  assign err     = ~reset & err_raw;

  // Only an idle FSM accepts new work; a held request is not re-issued.
  assign load_go  = (state == IDLE) & MemRead  & ~err_raw & ~reset;
  assign store_go = (state == IDLE) & MemWrite & ~err_raw & ~reset;

  // Store lane enables and lane-replicated write data
  always_comb begin
    be    = '0;
    wdata = rs2;
    case (funct3[1:0])
      2'b00: begin
        be[ALUOut[1:0]] = 1'b1;
        wdata           = {NUM_LANES{rs2[7:0]}};
      end
      2'b01: begin
        be    = ALUOut[1] ? 4'b1100 : 4'b0011;
        wdata = {2{rs2[15:0]}};
      end
      default: be = '1;
    endcase
  end

  // Single-cycle latency reads the live request; longer ones use the captured one.
  assign rd_req = (state == IDLE) ? cur_req : req_q;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [VEC_W-1:0] ram [DEPTH];
    always_ff @(posedge clk) begin
      if (store_go && be[l]) ram[cur_req.idx] <= wdata[l];
    end
    assign rd_word[l] = ram[rd_req.idx];
  end

  // Load lane select and extension
  always_comb begin
    sel_b    = rd_word[rd_req.lane];
    sel_h    = rd_req.lane[1] ? {rd_word[3], rd_word[2]} : {rd_word[1], rd_word[0]};
    load_ext = rd_word;
    case (rd_req.f3)
      3'b000:  load_ext = {{24{sel_b[7]}}, sel_b};
      3'b001:  load_ext = {{16{sel_h[15]}}, sel_h};
      3'b100:  load_ext = {24'd0, sel_b};
      3'b101:  load_ext = {16'd0, sel_h};
      default: load_ext = rd_word;
    endcase
  end

  // Load FSM next-state and stall
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall    = 1'b0;
    fill     = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_go) begin
          stall  = 1'b1;
          cnt_nx = CNT_W'(READ_LAT - 1);
          if (READ_LAT == 1) begin
            state_nx = DONE;
            fill     = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        stall  = 1'b1;
        cnt_nx = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_nx = DONE;
          fill     = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (reset) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      req_q  <= '0;
      load_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (load_go) req_q  <= cur_req;
      if (fill)    load_q <= load_ext;
    end
  end

  // Write-back select
  always_comb begin
    Res = '0;
    if (!reset) begin
      case (wb_sel)
        2'b00: Res = ALUOut;
        2'b01: Res = (state == DONE) ? load_q : 32'd0;
        2'b10: Res = PC_4;
        2'b11: Res = PC;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_wb.sv
// Scoreboard bench for data_mem_wb: two instances (READ_LAT 1 and 3) driven by
// a handshaking core model, checked against a byte-addressed reference memory.
module tb_data_mem_wb;

  localparam int ADDR_W = 10;
  localparam logic [31:0] NB = 32'(4 << ADDR_W);

  typedef struct packed {
    logic [31:0] res;
    logic        err;
    logic [3:0]  stalls;
    logic [15:0] id;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [2];
  logic        mr   [2];
  logic        mw   [2];
  logic [2:0]  f3   [2];
  logic [1:0]  sel  [2];
  logic [31:0] aluo [2];
  logic [31:0] wd   [2];
  logic [31:0] pc   [2];
  logic [31:0] pc4  [2];
  logic [31:0] res  [2];
  logic        stall[2];
  logic        err  [2];
  logic        act  [2];

  int   n_vec = 0;
  int   n_miss = 0;
  int   op_id = 0;
  int   scnt [2] = '{0, 0};
  exp_t q0 [$];
  exp_t q1 [$];
  logic [7:0] mdl [bit [32:0]];

  data_mem_wb #(.ADDR_W(ADDR_W), .READ_LAT(1)) u_lat1 (
    .clk(clk), .reset(rst[0]), .MemRead(mr[0]), .MemWrite(mw[0]), .funct3(f3[0]),
    .wb_sel(sel[0]), .ALUOut(aluo[0]), .rs2(wd[0]), .PC(pc[0]), .PC_4(pc4[0]),
    .Res(res[0]), .stall(stall[0]), .err(err[0])
  );

  data_mem_wb #(.ADDR_W(ADDR_W), .READ_LAT(3)) u_lat3 (
    .clk(clk), .reset(rst[1]), .MemRead(mr[1]), .MemWrite(mw[1]), .funct3(f3[1]),
    .wb_sel(sel[1]), .ALUOut(aluo[1]), .rs2(wd[1]), .PC(pc[1]), .PC_4(pc4[1]),
    .Res(res[1]), .stall(stall[1]), .err(err[1])
  );

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Reference: memory is a byte map; accesses are sz consecutive little-endian bytes.
  task automatic predict(input int d, input logic rs, input logic r, input logic w,
                         input logic [2:0] f, input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] data, input logic [31:0] p, output exp_t e);
    logic [31:0] sz;
    logic [31:0] v;
    bit          bad;
    bit [32:0]   k;
    case (f)
      3'b000, 3'b100: sz = 1;
      3'b001, 3'b101: sz = 2;
      3'b010:         sz = 4;
      default:        sz = 0;
    endcase
    bad = 1'b0;
    if (r || w) begin
      if (r && w) bad = 1'b1;
      if (sz == 0) bad = 1'b1;
      if (w && f[2]) bad = 1'b1;
      if (a >= NB) bad = 1'b1;
      if (sz != 0 && (a % sz) != 0) bad = 1'b1;
    end
    v = '0;
    if (!rs && r && !bad) begin
      for (int i = 0; i < int'(sz); i++) begin
        k = {d[0], a + 32'(i)};
        v[8*i +: 8] = mdl.exists(k) ? mdl[k] : 8'hxx;
      end
      if (!f[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
    end
    if (!rs && w && !bad)
      for (int i = 0; i < int'(sz); i++) mdl[{d[0], a + 32'(i)}] = data[8*i +: 8];
    e.err    = rs ? 1'b0 : bad;
    e.stalls = (!rs && r && !bad) ? 4'(lat(d)) : 4'd0;
    e.id     = '0;
    if (rs) e.res = '0;
    else begin
      case (s)
        2'b00: e.res = a;
        2'b01: e.res = (r && !bad) ? v : 32'd0;
        2'b10: e.res = p + 32'd4;
        default: e.res = p;
      endcase
    end
  endtask

  // Core model: present one request, hold it while stalled, advance on release.
  task automatic op(input int d, input logic r, input logic w, input logic [2:0] f,
                    input logic [1:0] s, input logic [31:0] a, input logic [31:0] data,
                    input logic [31:0] p);
    exp_t e;
    int   n;
    predict(d, rst[d], r, w, f, s, a, data, p, e);
    e.id = 16'(op_id);
    op_id++;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    mr[d] = r; mw[d] = w; f3[d] = f; sel[d] = s; aluo[d] = a; wd[d] = data;
    pc[d] = p; pc4[d] = p + 32'd4; act[d] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall[d] !== 1'b0 && n < 16);
    if (stall[d] !== 1'b0) begin
      n_vec++;
      n_miss++;
      $display("FAIL dut%0d op%0d timeout: stall=%b after %0d cycles, required 0", d, e.id, stall[d], n);
    end
    @(posedge clk);
    #1;
    act[d] = 1'b0; mr[d] = 1'b0; mw[d] = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %08h, required %08h", name, got, want);
    end
  endtask

  // Monitor: counts stall cycles of the presented request, pops on release.
  always @(negedge clk) begin : mon
    exp_t e;
    bit   empty;
    for (int d = 0; d < 2; d++) begin
      if (act[d] === 1'b1) begin
        if (stall[d] === 1'b1) scnt[d]++;
        else begin
          empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
          n_vec++;
          if (empty) begin
            n_miss++;
            $display("FAIL dut%0d unexpected completion: no entry queued", d);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            if (res[d] !== e.res || err[d] !== e.err || scnt[d] != int'(e.stalls)) begin
              n_miss++;
              $display("FAIL dut%0d op%0d: Res=%08h err=%b stall_cycles=%0d, required Res=%08h err=%b stall_cycles=%0d",
                       d, e.id, res[d], err[d], scnt[d], e.res, e.err, e.stalls);
            end
          end
          scnt[d] = 0;
        end
      end
    end
  end

  task automatic rand_op(input int d);
    logic       r, w;
    logic [2:0] f;
    logic [31:0] a;
    int         k;
    k = $urandom_range(0, 19);
    r = (k < 9);
    w = (k >= 9 && k < 16);
    if (k == 16) begin r = 1'b1; w = 1'b1; end
    case ($urandom_range(0, 5))
      0: f = 3'b000;
      1: f = 3'b001;
      2: f = 3'b010;
      3: f = 3'b100;
      4: f = 3'b101;
      default: f = 3'($urandom);
    endcase
    a = 32'($urandom_range(0, 255));
    if ($urandom_range(0, 3) != 0) begin
      if (f[1:0] == 2'b01) a[0] = 1'b0;
      if (f[1:0] == 2'b10) a[1:0] = 2'b00;
    end
    if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(12, 31));
    op(d, r, w, f, 2'($urandom), a, 32'($urandom), 32'($urandom) & ~32'd3);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; mr[d] = 1'b0; mw[d] = 1'b0; f3[d] = '0; sel[d] = '0;
      aluo[d] = '0; wd[d] = '0; pc[d] = '0; pc4[d] = '0; act[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) op(d, 1'b0, 1'b0, 3'b010, 2'b00, 32'h1234, 32'h0, 32'h0);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(posedge clk);
    #1;

    for (int d = 0; d < 2; d++) begin
      op(d, 1'b0, 1'b1, 3'b010, 2'b00, 32'h10, 32'h8899AABB, 32'h100);
      op(d, 1'b1, 1'b0, 3'b000, 2'b01, 32'h11, 32'h0, 32'h104);
      op(d, 1'b1, 1'b0, 3'b100, 2'b01, 32'h11, 32'h0, 32'h108);
      op(d, 1'b1, 1'b0, 3'b001, 2'b01, 32'h12, 32'h0, 32'h10C);
      op(d, 1'b1, 1'b0, 3'b010, 2'b01, 32'h10, 32'h0, 32'h110);
      op(d, 1'b0, 1'b1, 3'b000, 2'b00, 32'h13, 32'hCCCCCC55, 32'h114);
      op(d, 1'b1, 1'b0, 3'b010, 2'b01, 32'h10, 32'h0, 32'h118);
      op(d, 1'b0, 1'b1, 3'b010, 2'b00, 32'h20, 32'h13572468, 32'h11C);
      op(d, 1'b0, 1'b1, 3'b001, 2'b01, 32'h21, 32'hFFFFFFFF, 32'h120);
      op(d, 1'b1, 1'b0, 3'b010, 2'b01, 32'h22, 32'h0, 32'h124);
      op(d, 1'b1, 1'b0, 3'b010, 2'b01, 32'h20, 32'h0, 32'h128);
      op(d, 1'b1, 1'b0, 3'b010, 2'b01, 32'h00010000, 32'h0, 32'h12C);
      op(d, 1'b0, 1'b0, 3'b000, 2'b10, 32'h0, 32'h0, 32'h400);
      op(d, 1'b0, 1'b0, 3'b000, 2'b11, 32'h0, 32'h0, 32'h400);
    end

    // Reset during the second stall cycle of a 3-cycle load
    mr[1] = 1'b1; mw[1] = 1'b0; f3[1] = 3'b010; sel[1] = 2'b01; aluo[1] = 32'h10;
    @(negedge clk);
    chk("abort_first_stall", 32'(stall[1]), 32'd1);
    @(posedge clk);
    #1;
    rst[1] = 1'b1;
    @(negedge clk);
    chk("abort_reset_stall", 32'(stall[1]), 32'd0);
    chk("abort_reset_res", res[1], 32'd0);
    @(posedge clk);
    #1;
    rst[1] = 1'b0; mr[1] = 1'b0;
    @(negedge clk);
    chk("abort_after_stall", 32'(stall[1]), 32'd0);
    chk("abort_after_res", res[1], 32'd0);
    chk("abort_after_err", 32'(err[1]), 32'd0);
    @(posedge clk);
    #1;
    op(1, 1'b1, 1'b0, 3'b010, 2'b01, 32'h10, 32'h0, 32'h200);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++)
        op(d, 1'b0, 1'b1, 3'b010, 2'b00, 32'(i * 4), 32'($urandom), 32'h300);
      repeat (200) rand_op(d);
    end

    repeat (4) @(posedge clk);
    n_vec++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, required 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
